// File: rtl/cpu_pkg.sv
// Shared CPU constants and ALU op encodings used across the datapath slice.
package cpu_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int CTRL_W  = 4;
    localparam int SHAMT_W = 5;

    typedef enum logic [CTRL_W-1:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_XOR   = 4'b0011,
        ALU_ORI   = 4'b0100,
        ALU_ADDIU = 4'b0101,
        ALU_SUB   = 4'b0110,
        ALU_ADDI  = 4'b0111,
        ALU_SLL   = 4'b1000,
        ALU_SLT   = 4'b1001,
        ALU_LUI   = 4'b1111
    } alu_op_e;

endpackage

// File: rtl/ex_operand_stage_if.sv
// ID -> EX instruction bundle plus the flush/stall handshake between ID and the operand stage.
interface ex_operand_stage_if #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_AW = cpu_pkg::REG_AW,
    parameter int CTRL_W = cpu_pkg::CTRL_W
) ();

    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic [REG_AW-1:0] id_rd;
    logic [DATA_W-1:0] id_rs_val;
    logic [DATA_W-1:0] id_rt_val;
    logic [DATA_W-1:0] id_imm;
    logic              id_alu_src;
    logic [CTRL_W-1:0] id_alu_ctrl;
    logic [4:0]        id_shamt;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              flush;
    logic              stall_id;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_rs_val, id_rt_val, id_imm, id_alu_src, id_alu_ctrl, id_shamt,
               id_reg_write, id_mem_read, id_mem_write, flush,
        input  stall_id
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_rs_val, id_rt_val, id_imm, id_alu_src, id_alu_ctrl, id_shamt,
               id_reg_write, id_mem_read, id_mem_write, flush,
        output stall_id
    );

endinterface

// File: rtl/fwd_unit.sv
// Per-operand forwarding select: MEM result beats WB result beats the registered value; r0 never forwards.
module fwd_unit #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_AW = cpu_pkg::REG_AW,
    parameter bit EN     = 1'b1
) (
    input  logic [REG_AW-1:0] idx,
    input  logic [DATA_W-1:0] reg_val,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] fwd_val
);

    if (EN) begin : g_fwd
        always_comb begin
            fwd_val = reg_val;
            if (idx != '0) begin
                if (mem_reg_write && (mem_rd == idx)) begin
                    fwd_val = mem_result;
                end else if (wb_reg_write && (wb_rd == idx)) begin
                    fwd_val = wb_result;
                end
            end
        end
    end else begin : g_bypass
        // Without forwarding the stage stalls instead, so the sources are deliberately ignored.
        logic unused_srcs;
        assign unused_srcs = ^{idx, mem_reg_write, mem_rd, mem_result,
                               wb_reg_write, wb_rd, wb_result};
        assign fwd_val     = reg_val;
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with operand forwarding and hazard stall. Define EX_FORWARD_EN for MEM/WB
// forwarding with load-use stalls; otherwise any pending EX/MEM write to a used source stalls ID.
module ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_AW = cpu_pkg::REG_AW,
    parameter int CTRL_W = cpu_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    ex_operand_stage_if.slave id_bus,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic              ex_valid,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [4:0]        alu_shamt,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs_val;
        logic [DATA_W-1:0] rt_val;
        logic [DATA_W-1:0] imm;
        logic              alu_src;
        logic [CTRL_W-1:0] alu_ctrl;
        logic [4:0]        shamt;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } id_ex_t;

    id_ex_t            ex_q;
    id_ex_t            id_d;
    logic              hazard;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

`ifdef EX_FORWARD_EN
    localparam bit FWD_EN = 1'b1;

    // Only a load in EX cannot be forwarded in time; everything else comes from MEM/WB.
    always_comb begin
        hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_bus.id_valid &&
                 ((id_bus.id_uses_rs && (id_bus.id_rs == ex_q.rd)) ||
                  (id_bus.id_uses_rt && (id_bus.id_rt == ex_q.rd)));
    end
`else
    localparam bit FWD_EN = 1'b0;

    logic rs_busy;
    logic rt_busy;

    // WB writers are not checked: the register file is write-through.
    always_comb begin
        rs_busy = id_bus.id_uses_rs && (id_bus.id_rs != '0) &&
                  ((ex_q.valid && ex_q.reg_write && (id_bus.id_rs == ex_q.rd)) ||
                   (mem_reg_write && (id_bus.id_rs == mem_rd)));
        rt_busy = id_bus.id_uses_rt && (id_bus.id_rt != '0) &&
                  ((ex_q.valid && ex_q.reg_write && (id_bus.id_rt == ex_q.rd)) ||
                   (mem_reg_write && (id_bus.id_rt == mem_rd)));
        hazard  = id_bus.id_valid && (rs_busy || rt_busy);
    end
`endif

    assign id_bus.stall_id = hazard && !id_bus.flush && !rst;

    always_comb begin
        // NOTE: full default first so every path assigns id_d and no latch is inferred.
        id_d = '0;
        if (!(id_bus.flush || hazard)) begin
            id_d.valid     = id_bus.id_valid;
            id_d.rs        = id_bus.id_rs;
            id_d.rt        = id_bus.id_rt;
            id_d.rd        = id_bus.id_rd;
            id_d.rs_val    = id_bus.id_rs_val;
            id_d.rt_val    = id_bus.id_rt_val;
            id_d.imm       = id_bus.id_imm;
            id_d.alu_src   = id_bus.id_alu_src;
            id_d.alu_ctrl  = id_bus.id_alu_ctrl;
            id_d.shamt     = id_bus.id_shamt;
            id_d.reg_write = id_bus.id_reg_write && id_bus.id_valid;
            id_d.mem_read  = id_bus.id_mem_read  && id_bus.id_valid;
            id_d.mem_write = id_bus.id_mem_write && id_bus.id_valid;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= id_d;
        end
    end

    fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .EN(FWD_EN)) u_fwd_rs (
        .idx           (ex_q.rs),
        .reg_val       (ex_q.rs_val),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result),
        .fwd_val       (fwd_rs)
    );

    fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .EN(FWD_EN)) u_fwd_rt (
        .idx           (ex_q.rt),
        .reg_val       (ex_q.rt_val),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result),
        .fwd_val       (fwd_rt)
    );

    assign ex_valid      = ex_q.valid;
    assign alu_a         = fwd_rs;
    assign alu_b         = ex_q.alu_src ? ex_q.imm : fwd_rt;
    assign alu_ctrl      = ex_q.alu_ctrl;
    assign alu_shamt     = ex_q.shamt;
    assign ex_store_data = fwd_rt;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage; expectations follow whichever EX_FORWARD_EN build is compiled.
module tb_ex_operand_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        ex_valid;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [4:0]  alu_shamt;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;

    int checks   = 0;
    int failures = 0;

    ex_operand_stage_if id_bus ();

    ex_operand_stage dut (
        .clk           (clk),
        .rst           (rst),
        .id_bus        (id_bus),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result),
        .ex_valid      (ex_valid),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_ctrl      (alu_ctrl),
        .alu_shamt     (alu_shamt),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic urs, input logic urt,
                          input logic [31:0] rsv, input logic [31:0] rtv, input logic [31:0] imm,
                          input logic src, input logic [3:0] ctrl,
                          input logic rw, input logic mr, input logic mw);
        id_bus.id_valid     = v;
        id_bus.id_rs        = rs;
        id_bus.id_rt        = rt;
        id_bus.id_rd        = rd;
        id_bus.id_uses_rs   = urs;
        id_bus.id_uses_rt   = urt;
        id_bus.id_rs_val    = rsv;
        id_bus.id_rt_val    = rtv;
        id_bus.id_imm       = imm;
        id_bus.id_alu_src   = src;
        id_bus.id_alu_ctrl  = ctrl;
        id_bus.id_shamt     = 5'd0;
        id_bus.id_reg_write = rw;
        id_bus.id_mem_read  = mr;
        id_bus.id_mem_write = mw;
    endtask

    task automatic clr_fwd();
        mem_reg_write = 1'b0;
        mem_rd        = 5'd0;
        mem_result    = 32'h0;
        wb_reg_write  = 1'b0;
        wb_rd         = 5'd0;
        wb_result     = 32'h0;
    endtask

    initial begin
        rst          = 1'b1;
        id_bus.flush = 1'b0;
        clr_fwd();

        // Reset with a junk instruction and a matching MEM writer present.
        set_id(1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678,
               1'b0, 4'b1111, 1'b1, 1'b1, 1'b1);
        id_bus.id_shamt = 5'd31;
        mem_reg_write   = 1'b1;
        mem_rd          = 5'd7;
        mem_result      = 32'hFFFFFFFF;
        tick();
        tick();
        check("rst_stall",      32'(id_bus.stall_id), 32'd0);
        check("rst_ex_valid",   32'(ex_valid),        32'd0);
        check("rst_alu_a",      alu_a,                32'h0);
        check("rst_alu_b",      alu_b,                32'h0);
        check("rst_alu_ctrl",   32'(alu_ctrl),        32'd0);
        check("rst_shamt",      32'(alu_shamt),       32'd0);
        check("rst_ex_rd",      32'(ex_rd),           32'd0);
        check("rst_reg_write",  32'(ex_reg_write),    32'd0);
        check("rst_mem_read",   32'(ex_mem_read),     32'd0);
        check("rst_mem_write",  32'(ex_mem_write),    32'd0);
        check("rst_store_data", ex_store_data,        32'h0);

        // ADDI r3 = r1 + 4 appears in EX one cycle after release.
        rst = 1'b0;
        clr_fwd();
        set_id(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 32'h100, 32'h0, 32'h4,
               1'b1, ALU_ADDI, 1'b1, 1'b0, 1'b0);
        id_bus.id_shamt = 5'd5;
        settle();
        check("rel_stall", 32'(id_bus.stall_id), 32'd0);
        tick();
        check("a_ex_valid",  32'(ex_valid),     32'd1);
        check("a_alu_a",     alu_a,             32'h100);
        check("a_alu_b",     alu_b,             32'h4);
        check("a_alu_ctrl",  32'(alu_ctrl),     32'(ALU_ADDI));
        check("a_shamt",     32'(alu_shamt),    32'd5);
        check("a_ex_rd",     32'(ex_rd),        32'd3);
        check("a_reg_write", 32'(ex_reg_write), 32'd1);

`ifdef EX_FORWARD_EN
        // MEM forward onto rs; immediate still selected for b.
        set_id(1'b1, 5'd3, 5'd0, 5'd6, 1'b1, 1'b0, 32'h0, 32'h0, 32'h4,
               1'b1, ALU_ADD, 1'b1, 1'b0, 1'b0);
        tick();
        mem_reg_write = 1'b1;
        mem_rd        = 5'd3;
        mem_result    = 32'h10;
        settle();
        check("memfwd_alu_a", alu_a, 32'h10);
        check("memfwd_alu_b", alu_b, 32'h4);

        // MEM beats WB, then WB alone, then the registered value.
        set_id(1'b1, 5'd0, 5'd5, 5'd7, 1'b0, 1'b1, 32'h0, 32'hDEAD, 32'h0,
               1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0);
        clr_fwd();
        tick();
        mem_reg_write = 1'b1;
        mem_rd        = 5'd5;
        mem_result    = 32'h1;
        wb_reg_write  = 1'b1;
        wb_rd         = 5'd5;
        wb_result     = 32'h2;
        settle();
        check("prio_alu_b", alu_b,         32'h1);
        check("prio_store", ex_store_data, 32'h1);
        mem_reg_write = 1'b0;
        settle();
        check("wbfwd_alu_b", alu_b, 32'h2);
        wb_reg_write = 1'b0;
        settle();
        check("nofwd_alu_b", alu_b,         32'hDEAD);
        check("nofwd_store", ex_store_data, 32'hDEAD);

        // Index 0 never forwards.
        mem_reg_write = 1'b1;
        mem_rd        = 5'd0;
        mem_result    = 32'hFFFFFFFF;
        wb_reg_write  = 1'b1;
        wb_rd         = 5'd0;
        wb_result     = 32'hFFFFFFFF;
        settle();
        check("r0_alu_a", alu_a, 32'h0);

        // Load-use: LW r4 in EX, ADD reading r4 in ID.
        set_id(1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 32'h200, 32'h0, 32'h8,
               1'b1, ALU_ADD, 1'b1, 1'b1, 1'b0);
        clr_fwd();
        tick();
        set_id(1'b1, 5'd4, 5'd2, 5'd8, 1'b1, 1'b1, 32'h0, 32'h3, 32'h0,
               1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0);
        settle();
        check("lu_stall", 32'(id_bus.stall_id), 32'd1);
        tick();
        check("lu_bubble_valid", 32'(ex_valid),     32'd0);
        check("lu_bubble_rw",    32'(ex_reg_write), 32'd0);
        check("lu_stall_clears", 32'(id_bus.stall_id), 32'd0);
        wb_reg_write = 1'b1;
        wb_rd        = 5'd4;
        wb_result    = 32'h55;
        tick();
        check("lu_ex_valid", 32'(ex_valid), 32'd1);
        check("lu_alu_a",    alu_a,         32'h55);
        check("lu_alu_b",    alu_b,         32'h3);

        // A non-load producer in EX does not stall.
        set_id(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0,
               1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0);
        settle();
        check("alu_dep_no_stall", 32'(id_bus.stall_id), 32'd0);

        // Flush together with load-use: no stall, bubble loaded.
        set_id(1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 32'h200, 32'h0, 32'h8,
               1'b1, ALU_ADD, 1'b1, 1'b1, 1'b0);
        clr_fwd();
        tick();
        set_id(1'b1, 5'd4, 5'd2, 5'd8, 1'b1, 1'b1, 32'h0, 32'h3, 32'h0,
               1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0);
        id_bus.flush = 1'b1;
        settle();
        check("flush_lu_stall", 32'(id_bus.stall_id), 32'd0);
        tick();
        check("flush_ex_valid", 32'(ex_valid),     32'd0);
        check("flush_rw",       32'(ex_reg_write), 32'd0);
        id_bus.flush = 1'b0;
`else
        // Matching MEM/WB writers are ignored by the operand path.
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
               1'b0, ALU_AND, 1'b0, 1'b0, 1'b0);
        mem_reg_write = 1'b1;
        mem_rd        = 5'd1;
        mem_result    = 32'h10;
        wb_reg_write  = 1'b1;
        wb_rd         = 5'd1;
        wb_result     = 32'h20;
        settle();
        check("nofwd_alu_a",    alu_a,                32'h100);
        check("idle_id_stall",  32'(id_bus.stall_id), 32'd0);

        // ADD reads r3 while its producer moves EX -> MEM -> WB.
        clr_fwd();
        set_id(1'b1, 5'd3, 5'd2, 5'd8, 1'b1, 1'b1, 32'h11, 32'h22, 32'h0,
               1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0);
        settle();
        check("ex_hz_stall", 32'(id_bus.stall_id), 32'd1);
        tick();
        check("ex_hz_bubble_valid", 32'(ex_valid),     32'd0);
        check("ex_hz_bubble_rw",    32'(ex_reg_write), 32'd0);
        mem_reg_write = 1'b1;
        mem_rd        = 5'd3;
        settle();
        check("mem_hz_stall", 32'(id_bus.stall_id), 32'd1);
        tick();
        check("mem_hz_bubble_valid", 32'(ex_valid), 32'd0);
        clr_fwd();
        wb_reg_write = 1'b1;
        wb_rd        = 5'd3;
        settle();
        check("wb_no_stall", 32'(id_bus.stall_id), 32'd0);
        tick();
        check("hz_ex_valid", 32'(ex_valid),     32'd1);
        check("hz_alu_a",    alu_a,             32'h11);
        check("hz_alu_b",    alu_b,             32'h22);
        check("hz_store",    ex_store_data,     32'h22);
        check("hz_ex_rd",    32'(ex_rd),        32'd8);

        // Unused source and r0 never stall; a used rt matching MEM does.
        clr_fwd();
        set_id(1'b1, 5'd8, 5'd0, 5'd9, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0,
               1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0);
        mem_reg_write = 1'b1;
        mem_rd        = 5'd0;
        settle();
        check("unused_r0_no_stall", 32'(id_bus.stall_id), 32'd0);
        id_bus.id_rt = 5'd9;
        mem_rd       = 5'd9;
        settle();
        check("rt_mem_stall", 32'(id_bus.stall_id), 32'd1);
        id_bus.flush = 1'b1;
        settle();
        check("flush_hz_stall", 32'(id_bus.stall_id), 32'd0);
        tick();
        check("flush_ex_valid", 32'(ex_valid),     32'd0);
        check("flush_rw",       32'(ex_reg_write), 32'd0);
        id_bus.flush = 1'b0;
`endif

        // id_valid=0: data captured, controls forced low.
        clr_fwd();
        set_id(1'b0, 5'd1, 5'd0, 5'd10, 1'b1, 1'b0, 32'h33, 32'h0, 32'h0,
               1'b0, ALU_OR, 1'b1, 1'b1, 1'b1);
        tick();
        check("inv_ex_valid",  32'(ex_valid),     32'd0);
        check("inv_rw",        32'(ex_reg_write), 32'd0);
        check("inv_mr",        32'(ex_mem_read),  32'd0);
        check("inv_mw",        32'(ex_mem_write), 32'd0);
        check("inv_alu_a",     alu_a,             32'h33);

        // Reset during a stall clears state; the consumer is re-presented afterwards.
        set_id(1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 32'h200, 32'h0, 32'h8,
               1'b1, ALU_ADD, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd4, 5'd2, 5'd8, 1'b1, 1'b1, 32'h11, 32'h22, 32'h0,
               1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0);
        settle();
        check("mid_stall", 32'(id_bus.stall_id), 32'd1);
        rst = 1'b1;
        settle();
        check("mid_rst_stall", 32'(id_bus.stall_id), 32'd0);
        tick();
        check("mid_rst_valid", 32'(ex_valid), 32'd0);
        check("mid_rst_rd",    32'(ex_rd),    32'd0);
        check("mid_rst_alu_a", alu_a,         32'h0);
        rst = 1'b0;
        settle();
        check("post_rst_stall", 32'(id_bus.stall_id), 32'd0);
        tick();
        check("post_rst_valid", 32'(ex_valid), 32'd1);
        check("post_rst_rd",    32'(ex_rd),    32'd8);
        check("post_rst_alu_a", alu_a,         32'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
